zint_ack: RTL and testbench

CPU-side responder for the TSConf IM2 interrupt path. It watches the Z80 bus for the interrupt-acknowledge cycle and raises `intack` toward the interrupt generator. It then captures the IM2 vector and drives it onto the CPU data bus. It also snoops M1 opcode fetches for RETI/RETN, so the design knows when an interrupt service routine (ISR) finishes, and keeps an ISR nesting depth count.

---
 rtl/zint_pkg.sv | 21 ++
 rtl/zreti_dec.sv | 75 +++++++
 rtl/zint_ack.sv | 138 +++++++++++++
 tb/tb_zint_ack.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/zint_pkg.sv
// Shared types and constants for the IM2 interrupt-acknowledge responder.
package zint_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPT,
        DRIVE
    } ack_state_t;

    typedef enum logic {
        D_IDLE,
        D_ED
    } dec_state_t;

    localparam logic [7:0] OP_ED        = 8'hED;
    localparam logic [7:0] OP_RETI      = 8'h4D;
    localparam logic [7:0] OP_RETN      = 8'h45;
    localparam logic [7:0] DEFAULT_VECT = 8'hFF;

endpackage

// File: rtl/zreti_dec.sv
// Snoops Z80 M1 opcode fetches and pulses reti/retn when an ED 4D or ED 45
// sequence completes, so the acknowledge side can track ISR nesting.
module zreti_dec
    import zint_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic [7:0] di,
    output logic       reti,
    output logic       retn
);

    logic       rd_n_q;
    logic       fetch_q;
    logic [7:0] opcode_q;
    logic       fetch_end;
    dec_state_t dstate;

    // A fetch ends when rd_n rises after a clock of M1 memory-read; an INTA
    // cycle drives iorq_n low and therefore never qualifies.
    assign fetch_end = rd_n && !rd_n_q && fetch_q;

    // Keep one clock of bus history and hold the opcode seen during the fetch.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rd_n_q   <= 1'b1;
            fetch_q  <= 1'b0;
            opcode_q <= 8'h00;
        end else begin
            rd_n_q  <= rd_n;
            fetch_q <= !m1_n && !mreq_n && iorq_n;
            if (!m1_n && !mreq_n && !rd_n) begin
                opcode_q <= di;
            end
        end
    end

    // ED-prefix decoder; repeated ED prefixes keep it armed for the next fetch.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dstate <= D_IDLE;
            reti   <= 1'b0;
            retn   <= 1'b0;
        end else begin
            reti <= 1'b0;
            retn <= 1'b0;
            if (fetch_end) begin
                case (dstate)
                    D_IDLE: begin
                        if (opcode_q == OP_ED) begin
                            dstate <= D_ED;
                        end
                    end
                    D_ED: begin
                        if (opcode_q == OP_RETI) begin
                            reti   <= 1'b1;
                            dstate <= D_IDLE;
                        end else if (opcode_q == OP_RETN) begin
                            retn   <= 1'b1;
                            dstate <= D_IDLE;
                        end else if (opcode_q != OP_ED) begin
                            dstate <= D_IDLE;
                        end
                    end
                    default: dstate <= D_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/zint_ack.sv
// CPU-side IM2 responder: acknowledges INTA cycles toward the interrupt
// generator, latches and drives the vector, and tracks ISR nesting depth.
module zint_ack
    import zint_pkg::*;
#(
    parameter int ACK_WAIT = 2,
    parameter int DEPTH_W  = 3
) (
    input  logic               clk,
    input  logic               res,
    input  logic               int_n,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic               mreq_n,
    input  logic               rd_n,
    input  logic [7:0]         di,
    input  logic [7:0]         im2vect,
    output logic               intack,
    output logic               vect_oe,
    output logic [7:0]         dout,
    output logic               reti,
    output logic               retn,
    output logic [DEPTH_W-1:0] isr_depth
);

    localparam int CNT_W = (ACK_WAIT < 1) ? 1 : $clog2(ACK_WAIT + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    ack_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             int_n_q;
    logic             drive_done;
    logic             inta;
    logic             ret_pulse;

    assign inta      = !m1_n && !iorq_n;
    assign ret_pulse = reti || retn;

    zreti_dec u_dec (
        .clk    (clk),
        .res    (res),
        .m1_n   (m1_n),
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .di     (di),
        .reti   (reti),
        .retn   (retn)
    );

    // Remember the request line so only a request pending before INTA is honoured.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= int_n;
        end
    end

    // Acknowledge FSM: hold intack while the generator settles, capture the
    // vector, then drive it until the CPU ends the IORQ cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            intack     <= 1'b0;
            vect_oe    <= 1'b0;
            dout       <= DEFAULT_VECT;
            drive_done <= 1'b0;
        end else begin
            drive_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inta && !int_n_q) begin
                        state    <= REQ;
                        intack   <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (iorq_n) begin
                        state  <= IDLE;
                        intack <= 1'b0;
                    end else if (wait_cnt == CNT_W'(ACK_WAIT)) begin
                        state <= CAPT;
                        dout  <= im2vect;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                CAPT: begin
                    if (iorq_n) begin
                        state  <= IDLE;
                        intack <= 1'b0;
                    end else begin
                        state   <= DRIVE;
                        vect_oe <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (iorq_n) begin
                        state      <= IDLE;
                        intack     <= 1'b0;
                        vect_oe    <= 1'b0;
                        drive_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    intack  <= 1'b0;
                    vect_oe <= 1'b0;
                end
            endcase
        end
    end

    // Saturating nesting counter; simultaneous entry and return cancel out.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            isr_depth <= '0;
        end else begin
            case ({drive_done, ret_pulse})
                2'b10: begin
                    if (isr_depth != DEPTH_MAX) begin
                        isr_depth <= isr_depth + DEPTH_W'(1);
                    end
                end
                2'b01: begin
                    if (isr_depth != '0) begin
                        isr_depth <= isr_depth - DEPTH_W'(1);
                    end
                end
                default: isr_depth <= isr_depth;
            endcase
        end
    end

endmodule

// File: tb/tb_zint_ack.sv
// Self-checking bench for zint_ack: directed scenarios followed by a random
// mix of acknowledges, spurious INTAs and opcode fetches against a model.
module tb_zint_ack;

    localparam int AW = 2;
    localparam int DW = 3;
    localparam int DEPTH_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          res;
    logic          int_n;
    logic          m1_n;
    logic          iorq_n;
    logic          mreq_n;
    logic          rd_n;
    logic [7:0]    di;
    logic [7:0]    im2vect;
    logic          intack;
    logic          vect_oe;
    logic [7:0]    dout;
    logic          reti;
    logic          retn;
    logic [DW-1:0] isr_depth;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_dout;
    int         exp_depth;
    logic [7:0] last_op;

    zint_ack #(
        .ACK_WAIT (AW),
        .DEPTH_W  (DW)
    ) dut (
        .clk       (clk),
        .res       (res),
        .int_n     (int_n),
        .m1_n      (m1_n),
        .iorq_n    (iorq_n),
        .mreq_n    (mreq_n),
        .rd_n      (rd_n),
        .di        (di),
        .im2vect   (im2vect),
        .intack    (intack),
        .vect_oe   (vect_oe),
        .dout      (dout),
        .reti      (reti),
        .retn      (retn),
        .isr_depth (isr_depth)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic m1, input logic iorq, input logic mreq,
                                 input logic rd, input logic [7:0] d);
        m1_n   = m1;
        iorq_n = iorq;
        mreq_n = mreq;
        rd_n   = rd;
        di     = d;
    endtask

    // One INTA cycle held for 'hold' clocks. Timeline in clocks after INTA is
    // first sampled: intack for clocks 1..hold, vector latched at AW+2,
    // bus driven from AW+3 to hold, depth bumps two clocks after release.
    task automatic doAck(input logic req_low, input int hold, input logic [7:0] vect);
        bit drives;
        drives = req_low && (hold >= AW + 3);
        @(negedge clk);
        int_n   = req_low ? 1'b0 : 1'b1;
        im2vect = vect;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int n = 1; n <= hold + 3; n++) begin
            @(negedge clk);
            if (req_low && hold >= AW + 2 && n == AW + 2) exp_dout = vect;
            if (drives && n == hold + 2 && exp_depth < DEPTH_MAX) exp_depth++;
            checkOutput("intack", 32'(intack), 32'(req_low && n <= hold));
            checkOutput("vect_oe", 32'(vect_oe), 32'(req_low && n >= AW + 3 && n <= hold));
            checkOutput("dout", 32'(dout), 32'(exp_dout));
            checkOutput("depth_ack", 32'(isr_depth), 32'(exp_depth));
            if (n == hold) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        end
        int_n = 1'b1;
    endtask

    // One M1 opcode fetch; a return pulse is expected exactly when the
    // previous fetched opcode was the ED prefix.
    task automatic doFetch(input logic [7:0] op);
        bit exp_reti;
        bit exp_retn;
        exp_reti = (last_op == 8'hED) && (op == 8'h4D);
        exp_retn = (last_op == 8'hED) && (op == 8'h45);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, op);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
        @(negedge clk);
        checkOutput("reti", 32'(reti), 32'(exp_reti));
        checkOutput("retn", 32'(retn), 32'(exp_retn));
        checkOutput("depth_pre", 32'(isr_depth), 32'(exp_depth));
        @(negedge clk);
        if ((exp_reti || exp_retn) && exp_depth > 0) exp_depth--;
        checkOutput("reti_end", 32'(reti), 32'(0));
        checkOutput("retn_end", 32'(retn), 32'(0));
        checkOutput("depth_ret", 32'(isr_depth), 32'(exp_depth));
        last_op = op;
    endtask

    task automatic resetModel();
        exp_dout  = 8'hFF;
        exp_depth = 0;
        last_op   = 8'h00;
    endtask

    initial begin
        logic [7:0] op_tbl [5];
        op_tbl = '{8'hED, 8'h4D, 8'h45, 8'h00, 8'hED};

        res     = 1'b1;
        int_n   = 1'b1;
        im2vect = 8'h00;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_intack", 32'(intack), 32'(0));
        checkOutput("rst_vect_oe", 32'(vect_oe), 32'(0));
        checkOutput("rst_dout", 32'(dout), 32'hFF);
        checkOutput("rst_reti", 32'(reti), 32'(0));
        checkOutput("rst_retn", 32'(retn), 32'(0));
        checkOutput("rst_depth", 32'(isr_depth), 32'(0));
        res = 1'b0;
        @(negedge clk);

        $display("[TB] basic acknowledge and spurious INTA");
        doAck(1'b1, 12, 8'hFD);
        doAck(1'b0, 12, 8'h33);

        $display("[TB] RETI sequences");
        doFetch(8'hED); doFetch(8'h4D);
        doFetch(8'hED); doFetch(8'hED); doFetch(8'h4D);
        doFetch(8'hED); doFetch(8'h00); doFetch(8'h4D);

        $display("[TB] depth saturation");
        for (int i = 0; i < 9; i++) doAck(1'b1, 6, 8'($urandom));
        checkOutput("sat_depth", 32'(isr_depth), 32'(DEPTH_MAX));

        $display("[TB] reset during DRIVE");
        @(negedge clk);
        int_n   = 1'b0;
        im2vect = 8'h5A;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        repeat (AW + 4) @(negedge clk);
        checkOutput("pre_rst_vect_oe", 32'(vect_oe), 32'(1));
        #2 res = 1'b1;
        #1;
        checkOutput("async_vect_oe", 32'(vect_oe), 32'(0));
        checkOutput("async_intack", 32'(intack), 32'(0));
        checkOutput("async_dout", 32'(dout), 32'hFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        int_n = 1'b1;
        resetModel();
        @(negedge clk);
        res = 1'b0;
        doAck(1'b1, 8, 8'hC3);
        doFetch(8'hED); doFetch(8'h45);
        doFetch(8'hED); doFetch(8'h45);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: doAck(1'b1, int'($urandom_range(1, 12)), 8'($urandom));
                1: doAck(1'b0, int'($urandom_range(1, 8)), 8'($urandom));
                default: begin
                    if ($urandom_range(0, 4) == 0) doFetch(8'($urandom));
                    else doFetch(op_tbl[$urandom_range(0, 4)]);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
